// File: rtl/spi_regfile_periph_pkg.sv
// Shared types and frame-geometry helpers for the SPI register-file peripheral.
// Frame on the wire, MSB first: [R/W][address][data].
package spi_periph_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // R/W is the first bit on the wire, so it lands at the top of the shift register
  localparam int RW_BIT_FROM_MSB = 0;

  function automatic int frame_len(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

  function automatic int rw_bit(input int addr_w, input int data_w);
    return frame_len(addr_w, data_w) - 1 - RW_BIT_FROM_MSB;
  endfunction

endpackage

// File: rtl/spi_regfile_periph_if.sv
// Chip-pin bundle between an SPI controller and the register-file peripheral.
interface spi_regfile_periph_if;
  logic sclk;
  logic copi;
  logic ncs;
  logic cipo;
  logic cipo_oe;

  modport master (output sclk, output copi, output ncs, input cipo, input cipo_oe);
  modport slave  (input sclk, input copi, input ncs, output cipo, output cipo_oe);
endinterface

// File: rtl/spi_regfile_periph_sync_edge.sv
// Multi-flop synchroniser with rise/fall detection for one asynchronous pin.
// RST_LVL sets the reset value of the whole chain so reset release never fakes an edge.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_LVL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lvl_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RST_LVL}};
      lvl_d  <= RST_LVL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      lvl_d  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign lvl  = sync_q[SYNC_STAGES-1];
  assign rise = lvl & ~lvl_d;
  assign fall = ~lvl & lvl_d;

endmodule

// File: rtl/spi_regfile_periph.sv
// SPI (CPHA=0) slave front end driving a bank of NUM_REGS x DATA_W config registers.
// Optional readback of registers on cipo is enabled by defining SPI_READBACK_EN.
module spi_regfile_periph
  import spi_periph_pkg::*;
#(
  parameter int                ADDR_W      = 7,
  parameter int                DATA_W      = 8,
  parameter int                NUM_REGS    = 5,
  parameter int                SYNC_STAGES = 2,
  parameter logic              CPOL        = 1'b0,
  parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  spi_regfile_periph_if.slave          spi,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic [NUM_REGS-1:0]          wr_strobe,
  output logic                         addr_err,
  output logic                         frame_err
);

  localparam int FRAME_LEN = frame_len(ADDR_W, DATA_W);
  localparam int RW_BIT    = rw_bit(ADDR_W, DATA_W);
  localparam int CNT_W     = $clog2(FRAME_LEN + 2);

  localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0]  CNT_FRAME  = CNT_W'(FRAME_LEN);
  localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic copi_lvl, copi_rise_unused, copi_fall_unused;
  logic ncs_lvl, ncs_rise, ncs_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_LVL(CPOL)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din(spi.sclk),
    .lvl(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_LVL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .din(spi.copi),
    .lvl(copi_lvl), .rise(copi_rise_unused), .fall(copi_fall_unused)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_LVL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .din(spi.ncs),
    .lvl(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall)
  );

  logic sample_edge, shift_edge, sclk_lvl_unused;
  assign sample_edge     = CPOL ? sclk_fall : sclk_rise;
  assign shift_edge      = CPOL ? sclk_rise : sclk_fall;
  assign sclk_lvl_unused = sclk_lvl;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic                   fall_pend;
  logic                   start;
  logic [FRAME_LEN-1:0]   sr;
  logic [DATA_W-1:0]      regs [NUM_REGS];
  logic                   ncs_lvl_unused;

  // A frame start seen while committing is held one cycle so it is not lost
  assign start          = ncs_fall | fall_pend;
  assign ncs_lvl_unused = ncs_lvl;

  logic                frm_rw;
  logic [ADDR_W-1:0]   frm_addr;
  logic [DATA_W-1:0]   frm_data;
  logic                frm_addr_ok;

  assign frm_rw      = sr[RW_BIT];
  assign frm_addr    = sr[DATA_W +: ADDR_W];
  assign frm_data    = sr[DATA_W-1:0];
  assign frm_addr_ok = ({1'b0, frm_addr} < NUM_REGS_W);

  // Shift register is pure data: cleared at frame start, never reset
  always_ff @(posedge clk) begin
    if (state == IDLE && start)
      sr <= '0;
    else if (state == SHIFT && !ncs_rise && sample_edge)
      sr <= {sr[FRAME_LEN-2:0], copi_lvl};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      fall_pend <= 1'b0;
      wr_strobe <= '0;
      addr_err  <= 1'b0;
      frame_err <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else begin
      wr_strobe <= '0;
      addr_err  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          fall_pend <= 1'b0;
          if (start) begin
            state <= SHIFT;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          if (ncs_rise)
            state <= COMMIT;
          else if (sample_edge && cnt != CNT_MAX)
            cnt <= cnt + CNT_W'(1);
        end
        COMMIT: begin
          state     <= IDLE;
          fall_pend <= ncs_fall;
          if (cnt != CNT_FRAME)
            frame_err <= 1'b1;
          else if (!frm_addr_ok)
            addr_err <= 1'b1;
          else if (frm_rw) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (frm_addr == ADDR_W'(i)) begin
                regs[i]      <= frm_data;
                wr_strobe[i] <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < NUM_REGS; i++) regs_flat[i*DATA_W +: DATA_W] = regs[i];
  end

  logic cipo_q, cipo_oe_q;

`ifdef SPI_READBACK_EN
  localparam logic [CNT_W-1:0] CNT_HDR    = CNT_W'(1 + ADDR_W);
  localparam logic [CNT_W-1:0] CNT_HDR_M1 = CNT_W'(ADDR_W);

  logic [ADDR_W:0]    hdr_next;
  logic               hdr_done;
  logic               data_shift;
  logic               rd_frame;
  logic [DATA_W-1:0]  rd_val;
  logic [DATA_W-1:0]  snap;

  // Header completes on this sample edge: R/W and address are known one bit early
  assign hdr_next   = {sr[ADDR_W-1:0], copi_lvl};
  assign hdr_done   = (state == SHIFT) && !ncs_rise && sample_edge && (cnt == CNT_HDR_M1);
  assign data_shift = (state == SHIFT) && !ncs_rise && shift_edge && rd_frame &&
                      (cnt > CNT_HDR) && (cnt < CNT_FRAME);

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (hdr_next[ADDR_W-1:0] == ADDR_W'(i)) rd_val = regs[i];
  end

  // The MSB goes straight to cipo at snapshot time; snap holds the remaining bits
  always_ff @(posedge clk) begin
    if (hdr_done)
      snap <= rd_val << 1;
    else if (data_shift)
      snap <= snap << 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cipo_q    <= 1'b0;
      cipo_oe_q <= 1'b0;
      rd_frame  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cipo_q    <= 1'b0;
          rd_frame  <= 1'b0;
          cipo_oe_q <= start;
        end
        SHIFT: begin
          if (ncs_rise) begin
            cipo_q    <= 1'b0;
            cipo_oe_q <= 1'b0;
            rd_frame  <= 1'b0;
          end else if (hdr_done && !hdr_next[ADDR_W]) begin
            rd_frame <= 1'b1;
            cipo_q   <= rd_val[DATA_W-1];
          end else if (data_shift)
            cipo_q <= snap[DATA_W-1];
          else if (shift_edge && cnt >= CNT_FRAME)
            cipo_q <= 1'b0;
        end
        default: begin
          cipo_q    <= 1'b0;
          cipo_oe_q <= 1'b0;
          rd_frame  <= 1'b0;
        end
      endcase
    end
  end
`else
  assign cipo_q    = 1'b0;
  assign cipo_oe_q = 1'b0;
`endif

  assign spi.cipo    = cipo_q;
  assign spi.cipo_oe = cipo_oe_q;

endmodule

// File: tb/tb_spi_regfile_periph.sv
// Scoreboarded bench: a CPOL=0 and a CPOL=1 instance see the same frames (sclk inverted
// for the second) and are checked against a register-array model of the frame rules.
module tb_spi_regfile_periph;
  import spi_periph_pkg::*;

  localparam int NR = 5;
  localparam int S  = 2;
`ifdef SPI_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  typedef struct packed {
    logic [NR-1:0]   strobe;
    logic            aerr;
    logic            ferr;
    logic [NR*8-1:0] regs;
    logic [31:0]     cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic sclk, copi, ncs;
  logic [31:0] cyc = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  spi_regfile_periph_if spi0 ();
  spi_regfile_periph_if spi1 ();
  assign spi0.sclk = sclk;
  assign spi0.copi = copi;
  assign spi0.ncs  = ncs;
  assign spi1.sclk = ~sclk;
  assign spi1.copi = copi;
  assign spi1.ncs  = ncs;

  logic [NR*8-1:0] regs_flat0, regs_flat1;
  logic [NR-1:0]   wr_strobe0, wr_strobe1;
  logic            aerr0, aerr1, ferr0, ferr1;

  spi_regfile_periph #(.CPOL(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .spi(spi0), .regs_flat(regs_flat0),
    .wr_strobe(wr_strobe0), .addr_err(aerr0), .frame_err(ferr0)
  );

  spi_regfile_periph #(.CPOL(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .spi(spi1), .regs_flat(regs_flat1),
    .wr_strobe(wr_strobe1), .addr_err(aerr1), .frame_err(ferr1)
  );

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [7:0] m_regs [NR];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [NR*8-1:0] model_flat();
    logic [NR*8-1:0] f;
    for (int i = 0; i < NR; i++) f[i*8 +: 8] = m_regs[i];
    return f;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every output pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 &&
        ((|wr_strobe0) || aerr0 || ferr0 || (|wr_strobe1) || aerr1 || ferr1)) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_pulse: got strobe0=%b aerr0=%b ferr0=%b strobe1=%b aerr1=%b ferr1=%b, required no pulse",
                 wr_strobe0, aerr0, ferr0, wr_strobe1, aerr1, ferr1);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_cpol0", {wr_strobe0, aerr0, ferr0}, {mon_e.strobe, mon_e.aerr, mon_e.ferr});
        check("pulse_cpol1", {wr_strobe1, aerr1, ferr1}, {mon_e.strobe, mon_e.aerr, mon_e.ferr});
        check("regs_cpol0", regs_flat0, mon_e.regs);
        check("regs_cpol1", regs_flat1, mon_e.regs);
        check("commit_latency", cyc, mon_e.cyc);
      end
    end
  end

  task automatic send_bits(input logic [31:0] v, input int nb,
                           output logic [31:0] rx0, output logic [31:0] rx1,
                           output logic oe0, output logic oe1);
    rx0 = '0; rx1 = '0; oe0 = 1'b0; oe1 = 1'b0;
    ncs = 1'b0;
    tick(4);
    for (int i = nb - 1; i >= 0; i--) begin
      copi = v[i];
      tick(4);
      rx0 = {rx0[30:0], spi0.cipo};
      rx1 = {rx1[30:0], spi1.cipo};
      oe0 = oe0 | spi0.cipo_oe;
      oe1 = oe1 | spi1.cipo_oe;
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
    tick(4);
  endtask

  task automatic run_frame(input logic [31:0] v, input int nb, input int gap);
    logic [31:0] rx0, rx1, rx_req;
    logic        oe0, oe1, rw, has_evt;
    int          addr;
    exp_t        e;
    rw      = v[15];
    addr    = int'(v[14:8]);
    rx_req  = '0;
    has_evt = 1'b1;
    e       = '0;
    if (nb != 16) e.ferr = 1'b1;
    else if (addr >= NR) e.aerr = 1'b1;
    else if (rw) begin
      m_regs[addr]  = v[7:0];
      e.strobe[addr] = 1'b1;
    end else has_evt = 1'b0;
    if (RB && nb == 16 && !rw && addr < NR) rx_req = {24'd0, m_regs[addr]};
    e.regs = model_flat();
    send_bits(v, nb, rx0, rx1, oe0, oe1);
    ncs   = 1'b1;
    e.cyc = cyc + 32'(S + 2);
    if (has_evt) exp_q.push_back(e);
    check("cipo_bits_cpol0", rx0, rx_req);
    check("cipo_bits_cpol1", rx1, rx_req);
    check("cipo_oe_cpol0", oe0, RB);
    check("cipo_oe_cpol1", oe1, RB);
    tick(gap);
  endtask

  task automatic check_quiet(input string name);
    check({name, "_regs0"}, regs_flat0, model_flat());
    check({name, "_regs1"}, regs_flat1, model_flat());
    check({name, "_outs"}, {wr_strobe0, aerr0, ferr0, spi0.cipo, spi0.cipo_oe,
                            wr_strobe1, aerr1, ferr1, spi1.cipo, spi1.cipo_oe}, 64'd0);
  endtask

  function automatic logic [31:0] mk(input logic rw, input logic [6:0] a, input logic [7:0] d);
    return {16'd0, rw, a, d};
  endfunction

  initial begin
    logic [31:0] v, rx0, rx1;
    logic        oe0, oe1;
    int          nb, kind;
    rst_n = 1'b0; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
    for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
    tick(3);
    check_quiet("reset");
    rst_n = 1'b1;
    tick(4);

    run_frame(32'h82A5, 16, 6);
    run_frame(32'h87FF, 16, 6);
    run_frame(32'h8055, 16, 6);
    run_frame(32'h800, 12, 6);
    run_frame(32'h10001, 17, 6);
    run_frame(32'h843C, 16, 6);
    run_frame(32'h0400, 16, 6);
    run_frame(32'h0500, 16, 6);

    // Reset in the middle of a frame discards it entirely
    send_bits(32'h81FF >> 7, 9, rx0, rx1, oe0, oe1);
    rst_n = 1'b0;
    ncs   = 1'b1;
    sclk  = 1'b0;
    for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
    tick(3);
    rst_n = 1'b1;
    tick(4);
    check_quiet("midframe_reset");
    run_frame(32'h8111, 16, 6);

    run_frame(32'h8001, 16, 1);
    run_frame(32'h8102, 16, 6);

    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 5));
      nb   = 16;
      case (kind)
        0, 1: v = mk(1'b1, 7'($urandom_range(0, NR - 1)), 8'($urandom));
        2:    v = mk(1'($urandom_range(0, 1)), 7'($urandom_range(NR, 127)), 8'($urandom));
        3:    v = mk(1'b0, 7'($urandom_range(0, NR - 1)), 8'($urandom));
        4: begin
          nb = int'($urandom_range(1, 15));
          v  = {16'd0, 1'b1, 15'($urandom)} >> (16 - nb);
        end
        default: begin
          nb = int'($urandom_range(17, 20));
          v  = ({16'd0, 1'b1, 15'($urandom)} << (nb - 16)) | 32'($urandom_range(0, 15));
        end
      endcase
      run_frame(v, nb, int'($urandom_range(1, 8)));
    end

    tick(12);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check_quiet("final");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
